// File: rtl/core_wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with buffered MDU results
// onto the register-file write port and tracks in-flight MDU destinations.
module core_wb_arbiter #(
  parameter int IDX_W        = 5,
  parameter int DATA_W       = 64,
  parameter int NREGS        = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [IDX_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_stall,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [IDX_W-1:0]  mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  input  logic              issue_valid,
  input  logic [IDX_W-1:0]  issue_rd,
  output logic [NREGS-1:0]  busy,
  output logic              rf_wen,
  output logic [IDX_W-1:0]  wr_indx,
  output logic [DATA_W-1:0] wr_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT) + 1;

  logic [IDX_W-1:0]  rd_mem_r   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0]  count_r, count_nxt_s;
  logic [SC_W-1:0]   starve_r, starve_nxt_s;
  logic              alu_stall_r, stall_nxt_s;
  logic              rf_wen_r;
  logic [IDX_W-1:0]  wr_indx_r;
  logic [DATA_W-1:0] wr_data_r;
  logic [NREGS-1:0]  busy_r, busy_nxt_s;

  logic              empty_s, full_s, enq_s, deq_s, win_s;
  logic [IDX_W-1:0]  head_rd_s, win_rd_s;
  logic [DATA_W-1:0] head_data_s, win_data_s;

  assign empty_s     = (count_r == CNT_W'(0));
  assign full_s      = (count_r == CNT_W'(FIFO_DEPTH));
  assign head_rd_s   = rd_mem_r[rd_ptr_r];
  assign head_data_s = data_mem_r[rd_ptr_r];
  // Results for x0 complete the handshake but are never buffered.
  assign enq_s       = mdu_valid && !full_s && (mdu_rd != IDX_W'(0));

  assign mdu_ready = !full_s;
  assign alu_stall = alu_stall_r;
  assign busy      = busy_r;
  assign rf_wen    = rf_wen_r;
  assign wr_indx   = wr_indx_r;
  assign wr_data   = wr_data_r;

  // Select this cycle's writeback winner.
  always_comb begin
    deq_s      = 1'b0;
    win_s      = 1'b0;
    win_rd_s   = wr_indx_r;
    win_data_s = wr_data_r;
    if (alu_stall_r) begin
      if (!empty_s) begin
        deq_s      = 1'b1;
        win_s      = 1'b1;
        win_rd_s   = head_rd_s;
        win_data_s = head_data_s;
      end else begin
        deq_s = 1'b0;
      end
    end else if (alu_valid) begin
      win_s      = 1'b1;
      win_rd_s   = alu_rd;
      win_data_s = alu_data;
    end else if (!empty_s) begin
      deq_s      = 1'b1;
      win_s      = 1'b1;
      win_rd_s   = head_rd_s;
      win_data_s = head_data_s;
    end else begin
      win_s = 1'b0;
    end
  end

  // Starvation tracking: a head that loses STARVE_LIMIT times forces one stall cycle.
  always_comb begin
    stall_nxt_s  = 1'b0;
    starve_nxt_s = starve_r;
    if (empty_s || deq_s) begin
      starve_nxt_s = SC_W'(0);
    end else if (starve_r == SC_W'(STARVE_LIMIT - 1)) begin
      stall_nxt_s  = 1'b1;
      starve_nxt_s = SC_W'(0);
    end else begin
      starve_nxt_s = starve_r + SC_W'(1);
    end
  end

  // Occupancy and scoreboard next state; a same-cycle set beats the clear.
  always_comb begin
    count_nxt_s = count_r;
    case ({enq_s, deq_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    busy_nxt_s = busy_r;
    if (deq_s) begin
      busy_nxt_s[head_rd_s] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (issue_valid && (issue_rd != IDX_W'(0))) begin
      busy_nxt_s[issue_rd] = 1'b1;
    end else begin
      busy_nxt_s[0] = 1'b0;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rd_mem_r[i]   <= IDX_W'(0);
        data_mem_r[i] <= DATA_W'(0);
      end
    end else if (enq_s) begin
      rd_mem_r[wr_ptr_r]   <= mdu_rd;
      data_mem_r[wr_ptr_r] <= mdu_data;
    end
  end

  // Control state and registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r    <= PTR_W'(0);
      wr_ptr_r    <= PTR_W'(0);
      count_r     <= CNT_W'(0);
      starve_r    <= SC_W'(0);
      alu_stall_r <= 1'b0;
      rf_wen_r    <= 1'b0;
      wr_indx_r   <= IDX_W'(0);
      wr_data_r   <= DATA_W'(0);
      busy_r      <= NREGS'(0);
    end else begin
      if (enq_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (deq_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r     <= count_nxt_s;
      starve_r    <= starve_nxt_s;
      alu_stall_r <= stall_nxt_s;
      rf_wen_r    <= win_s && (win_rd_s != IDX_W'(0));
      wr_indx_r   <= win_rd_s;
      wr_data_r   <= win_data_s;
      busy_r      <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter: reset, x0 suppression, starvation,
// FIFO ordering across wrap, scoreboard and mid-operation reset.
module tb_core_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_stall;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [63:0] mdu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        rf_wen;
  logic [4:0]  wr_indx;
  logic [63:0] wr_data;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  core_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
    .rf_wen(rf_wen), .wr_indx(wr_indx), .wr_data(wr_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 64'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 64'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [63:0] d);
    chk({tag, "_wen"}, {63'd0, rf_wen}, 64'd1);
    chk({tag, "_idx"}, {59'd0, wr_indx}, {59'd0, rd});
    chk({tag, "_data"}, wr_data, d);
  endtask

  initial begin
    // Reset with garbage inputs
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'hFFFF;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 64'hBAD;
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick(); tick();
    chk("rst_wen", {63'd0, rf_wen}, 64'd0);
    chk("rst_busy", {32'd0, busy}, 64'd0);
    chk("rst_stall", {63'd0, alu_stall}, 64'd0);
    chk("rst_ready", {63'd0, mdu_ready}, 64'd1);
    chk("rst_idx", {59'd0, wr_indx}, 64'd0);
    chk("rst_data", wr_data, 64'd0);

    rst_n = 1'b1; idle();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hA5;
    tick();
    chk_wr("alu_first", 5'd5, 64'hA5);

    // x0 suppression
    idle();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h77;
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 64'h88;
    tick();
    chk("x0_wen", {63'd0, rf_wen}, 64'd0);
    chk("x0_ready", {63'd0, mdu_ready}, 64'd1);
    idle();
    tick();
    chk("x0_nodeq", {63'd0, rf_wen}, 64'd0);
    chk("x0_busy", {32'd0, busy}, 64'd0);

    // Contention: head loses 4 cycles, then one stall cycle drains it
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h10;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 64'h1234;
    tick();
    chk_wr("cont_c0", 5'd1, 64'h10);
    mdu_valid = 1'b0; mdu_rd = 5'd0;
    for (int i = 1; i <= 4; i++) begin
      alu_rd = 5'(i + 1); alu_data = 64'(32'h20 + i);
      tick();
      chk_wr("cont_alu", 5'(i + 1), 64'(32'h20 + i));
      chk("cont_stall", {63'd0, alu_stall}, (i == 4) ? 64'd1 : 64'd0);
    end
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'hDEAD;
    tick();
    chk_wr("cont_mdu", 5'd7, 64'h1234);
    chk("cont_stall_drop", {63'd0, alu_stall}, 64'd0);
    idle();
    tick();
    chk("cont_after", {63'd0, rf_wen}, 64'd0);

    // FIFO fill while ALU busy, drain in order, then wrap
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 64'hA0;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 64'h33;
    tick();
    chk("fill1_ready", {63'd0, mdu_ready}, 64'd1);
    alu_rd = 5'd11; alu_data = 64'hA1;
    mdu_rd = 5'd4; mdu_data = 64'h44;
    tick();
    chk("full_ready", {63'd0, mdu_ready}, 64'd0);
    chk_wr("full_alu", 5'd11, 64'hA1);
    idle();
    tick();
    chk_wr("drain3", 5'd3, 64'h33);
    chk("drain_ready", {63'd0, mdu_ready}, 64'd1);
    tick();
    chk_wr("drain4", 5'd4, 64'h44);
    mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 64'hC;
    tick();
    chk("wrap_none", {63'd0, rf_wen}, 64'd0);
    mdu_rd = 5'd13; mdu_data = 64'hD;
    tick();
    chk_wr("wrap12", 5'd12, 64'hC);
    mdu_rd = 5'd14; mdu_data = 64'hE;
    tick();
    chk_wr("wrap13", 5'd13, 64'hD);
    idle();
    tick();
    chk_wr("wrap14", 5'd14, 64'hE);
    tick();
    chk("wrap_empty", {63'd0, rf_wen}, 64'd0);

    // Scoreboard
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    chk("sb_set", {32'd0, busy}, 64'h200);
    idle();
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 64'h99;
    tick();
    chk("sb_inflight", {32'd0, busy}, 64'h200);
    idle();
    tick();
    chk_wr("sb_wr9", 5'd9, 64'h99);
    chk("sb_clear", {32'd0, busy}, 64'd0);
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 64'h9A;
    tick();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    chk_wr("sb_wr9b", 5'd9, 64'h9A);
    chk("sb_set_wins", {32'd0, busy}, 64'h200);
    idle();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h5;
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    chk_wr("sb_alu9", 5'd9, 64'h5);
    chk("sb_alu_keep", {32'd0, busy}, 64'h200);

    // Reset mid-operation
    idle();
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 64'h1;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 64'h3;
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    alu_rd = 5'd21; mdu_rd = 5'd5; mdu_data = 64'h5;
    tick();
    chk("mid_full", {63'd0, mdu_ready}, 64'd0);
    chk("mid_busy", {32'd0, busy}, 64'h208);
    idle();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", {32'd0, busy}, 64'd0);
    chk("mid_rst_ready", {63'd0, mdu_ready}, 64'd1);
    chk("mid_rst_wen", {63'd0, rf_wen}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_write", {63'd0, rf_wen}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/core_wb_arbiter.md
Name: core_wb_arbiter

Overview:
- Writeback arbiter that drives the register-file write port (wr_indx, wr_data, rf_wen).
- Merges single-cycle ALU results with multi-cycle MUL/DIV (MDU) results.
- Buffers MDU results in a small FIFO and prevents MDU starvation.
- Keeps a per-register pending scoreboard for in-flight MDU destinations, used by the issue stage for RAW hazard checks.

Parameters:
- IDX_W, 5, register index width.
- DATA_W, 64, register data width.
- NREGS, 32, number of architectural registers.
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, >=2).
- STARVE_LIMIT, 4, consecutive cycles an MDU result may lose arbitration before ALU is stalled.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- alu_valid  in  1  ALU result valid; no backpressure except alu_stall.
- alu_rd  in  IDX_W  ALU destination.
- alu_data  in  DATA_W  ALU result.
- alu_stall  out  1  registered; upstream must hold alu_valid=0 while high.
- mdu_valid  in  1  MDU result valid.
- mdu_ready  out  1  FIFO can accept; equals !full, combinational from state.
- mdu_rd  in  IDX_W  MDU destination.
- mdu_data  in  DATA_W  MDU result.
- issue_valid  in  1  MDU operation issued this cycle.
- issue_rd  in  IDX_W  destination of the issued MDU op.
- busy  out  NREGS  pending-write scoreboard, registered.
- rf_wen  out  1  registered write enable to the register file.
- wr_indx  out  IDX_W  registered write index.
- wr_data  out  DATA_W  registered write data.

Behaviour:
- Reset (rst_n=0 at posedge) clears every output and all state:
  - rf_wen, wr_indx, wr_data, alu_stall, busy all 0.
  - FIFO empty, so mdu_ready=1 after reset.
  - Starve counter 0.
  - Reset asserted mid-operation discards buffered results.
- MDU enqueue:
  - Handshake occurs when mdu_valid & mdu_ready.
  - If mdu_rd==0, the result is accepted and dropped, never enqueued.
- Per-cycle arbitration, in priority order:
  1. If alu_stall=1: ALU inputs are ignored and the FIFO head is dequeued, if non-empty.
  2. Else if alu_valid=1: the ALU wins; the FIFO head stays.
  3. Else if the FIFO is non-empty: the head is dequeued.
  4. Else: no write.
- Output latency: the winner is registered onto wr_indx/wr_data at the next posedge, so latency is 1 cycle.
  - rf_wen=1 only if the winner exists and its rd!=0.
  - With no winner, rf_wen=0 and wr_indx/wr_data hold their previous values.
  - The register file samples on negedge, so data is stable half a cycle after posedge.
- Same-cycle enqueue and dequeue while full:
  - Not allowed; mdu_ready is computed from current occupancy, so an enqueue needs a free slot.
  - When not full, simultaneous enqueue and dequeue keeps occupancy constant.
  - The pointers wrap modulo FIFO_DEPTH.
  - An occupancy counter of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
- No FIFO bypass: an MDU result is visible on the write port no earlier than 2 cycles after its handshake (enqueue cycle, then dequeue cycle).
- Starvation:
  - starve_cnt increments each cycle the FIFO is non-empty and the head is not dequeued.
  - It resets to 0 on any dequeue or when the FIFO is empty.
  - When starve_cnt reaches STARVE_LIMIT-1 and the head again loses, alu_stall is registered to 1 for exactly one cycle; that cycle the head is dequeued.
  - alu_stall never stays high for two consecutive cycles.
- Scoreboard:
  - issue_valid with issue_rd!=0 sets busy[issue_rd] at the next posedge.
  - An MDU-path write (rf_wen=1 sourced from the FIFO) clears busy[wr rd] at the same posedge the write is registered.
  - Set and clear of the same index in one cycle: set wins.
  - busy[0] is always 0.
  - ALU writes never touch busy.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with garbage inputs -> rf_wen=0, busy=0, alu_stall=0, mdu_ready=1; after release, alu_valid, alu_rd=5, alu_data=0xA5 -> next posedge rf_wen=1, wr_indx=5, wr_data=0xA5.
- x0 suppression: ALU rd=0 and MDU rd=0 results -> rf_wen stays 0; FIFO stays empty; mdu_ready stays 1.
- Contention: one MDU enqueue of rd=7, data=0x1234 while alu_valid on every cycle with STARVE_LIMIT=4 -> ALU writes 4 cycles; alu_stall=1 for one cycle; that cycle MDU head wins, giving rf_wen=1, wr_indx=7, wr_data=0x1234; alu_stall returns to 0 the next cycle.
- FIFO full/wrap: 2 MDU enqueues (rd 3, 4) with the ALU busy -> mdu_ready=0; drop alu_valid -> writes rd 3 then rd 4 in order; then 3 more enqueues interleaved with dequeues -> order preserved across pointer wrap.
- Scoreboard: issue rd=9 -> busy[9]=1; the MDU write of rd 9 clears it. In the cycle the MDU write of rd 9 is registered, also issue rd=9 -> busy[9] stays 1. An ALU write of rd 9 leaves busy[9] unchanged.
- Reset mid-operation: FIFO holding 2 entries and busy[3]=1, assert rst_n=0 -> FIFO empty, busy=0, no later write of the buffered entries.
